// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - NUM_LAYERS priority compositor with window, border/background and vblank-committed config
// Optional statistics output win_cnt0 enabled by LAYER_COMPOSITOR_STATS_EN.
module layer_compositor #(
    parameter int NUM_LAYERS = 2,
    parameter int COLOR_W    = 4,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9,
    parameter int COL_MIN    = 208,
    parameter int COL_MAX    = 432,
    parameter int ROW_MIN    = 96,
    parameter int ROW_MAX    = 384,
    parameter int CFG_AW     = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ROW_W-1:0]                    row,
    input  logic [COL_W-1:0]                    col,
    input  logic                                blank,
    input  logic                                vblank,
    input  logic                                hs_in,
    input  logic                                vs_in,
    output logic [ROW_W-1:0]                    off_row,
    output logic [COL_W-1:0]                    off_col,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0]     layer_rgb,
    input  logic                                cfg_wr,
    input  logic [CFG_AW-1:0]                   cfg_addr,
    input  logic [3*COLOR_W-1:0]                cfg_data,
    output logic [COLOR_W-1:0]                  vga_r,
    output logic [COLOR_W-1:0]                  vga_g,
    output logic [COLOR_W-1:0]                  vga_b,
    output logic                                hs_out,
    output logic                                vs_out,
    output logic                                win_hit,
    output logic [$clog2(NUM_LAYERS+1)-1:0]     win_layer
`ifdef LAYER_COMPOSITOR_STATS_EN
    ,
    output logic [15:0]                         win_cnt0
`endif
);

    localparam int CW = 3*COLOR_W;
    localparam int LW = $clog2(NUM_LAYERS+1);
    localparam logic [LW-1:0]    NO_LAYER = LW'(NUM_LAYERS);
    localparam logic [ROW_W:0]   R_MIN = (ROW_W+1)'(ROW_MIN);
    localparam logic [ROW_W:0]   R_MAX = (ROW_W+1)'(ROW_MAX);
    localparam logic [COL_W:0]   C_MIN = (COL_W+1)'(COL_MIN);
    localparam logic [COL_W:0]   C_MAX = (COL_W+1)'(COL_MAX);

    assign off_row = row - ROW_W'(ROW_MIN);
    assign off_col = col - COL_W'(COL_MIN);

    logic [CW-1:0]         key_sh  [NUM_LAYERS];
    logic [CW-1:0]         key_act [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] en_sh, en_act;
    logic [CW-1:0]         bord_sh, bord_act, bg_sh, bg_act;
    logic                  vblank_q;
    logic                  commit;

    assign commit = vblank && !vblank_q;

    // Shadow registers take writes every cycle; active copies follow only at the vblank rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                key_sh[i]  <= '0;
                key_act[i] <= '0;
            end
            en_sh    <= '1;
            en_act   <= '1;
            bord_sh  <= '1;
            bord_act <= '1;
            bg_sh    <= '0;
            bg_act   <= '0;
            vblank_q <= 1'b1;
        end else begin
            vblank_q <= vblank;
            if (cfg_wr) begin
                for (int i = 0; i < NUM_LAYERS; i++) begin
                    if (cfg_addr == CFG_AW'(i))
                        key_sh[i] <= cfg_data;
                end
                if (cfg_addr == CFG_AW'(NUM_LAYERS))
                    en_sh <= cfg_data[NUM_LAYERS-1:0];
                if (cfg_addr == CFG_AW'(NUM_LAYERS+1))
                    bord_sh <= cfg_data;
                if (cfg_addr == CFG_AW'(NUM_LAYERS+2))
                    bg_sh <= cfg_data;
            end
            if (commit) begin
                for (int i = 0; i < NUM_LAYERS; i++)
                    key_act[i] <= key_sh[i];
                en_act   <= en_sh;
                bord_act <= bord_sh;
                bg_act   <= bg_sh;
            end
        end
    end

    logic [NUM_LAYERS-1:0] opq_c;
    logic                  in_win_c;

    always_comb begin
        opq_c = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            opq_c[i] = en_act[i] && (layer_rgb[i*CW +: CW] != key_act[i]);
        in_win_c = ({1'b0, row} >= R_MIN) && ({1'b0, row} < R_MAX) &&
                   ({1'b0, col} >= C_MIN) && ({1'b0, col} < C_MAX);
    end

    logic [NUM_LAYERS*CW-1:0] rgb_s1;
    logic [NUM_LAYERS-1:0]    opq_s1;
    logic                     blank_s1, hs_s1, vs_s1, in_win_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_s1    <= '0;
            opq_s1    <= '0;
            blank_s1  <= 1'b0;
            hs_s1     <= 1'b0;
            vs_s1     <= 1'b0;
            in_win_s1 <= 1'b0;
        end else begin
            rgb_s1    <= layer_rgb;
            opq_s1    <= opq_c;
            blank_s1  <= blank;
            hs_s1     <= hs_in;
            vs_s1     <= vs_in;
            in_win_s1 <= in_win_c;
        end
    end

    logic [CW-1:0] sel_rgb;
    logic [LW-1:0] sel_layer;
    logic          sel_hit;

    // Descending scan so the lowest-index opaque layer is the last assignment and wins.
    always_comb begin
        sel_rgb   = '0;
        sel_layer = NO_LAYER;
        sel_hit   = 1'b0;
        if (blank_s1) begin
            sel_rgb = '0;
        end else if (!in_win_s1) begin
            sel_rgb = bord_act;
        end else begin
            sel_hit = 1'b1;
            sel_rgb = bg_act;
            for (int i = NUM_LAYERS-1; i >= 0; i--) begin
                if (opq_s1[i]) begin
                    sel_rgb   = rgb_s1[i*CW +: CW];
                    sel_layer = LW'(i);
                end
            end
        end
    end

    logic [CW-1:0] rgb_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_s2    <= '0;
            hs_out    <= 1'b0;
            vs_out    <= 1'b0;
            win_hit   <= 1'b0;
            win_layer <= NO_LAYER;
        end else begin
            rgb_s2    <= sel_rgb;
            hs_out    <= hs_s1;
            vs_out    <= vs_s1;
            win_hit   <= sel_hit;
            win_layer <= sel_layer;
        end
    end

    assign vga_r = rgb_s2[CW-1 -: COLOR_W];
    assign vga_g = rgb_s2[2*COLOR_W-1 -: COLOR_W];
    assign vga_b = rgb_s2[COLOR_W-1:0];

`ifdef LAYER_COMPOSITOR_STATS_EN
    logic [15:0] cnt0;
    logic        win0;

    assign win0 = !blank_s1 && (sel_layer == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0     <= '0;
            win_cnt0 <= '0;
        end else if (commit) begin
            win_cnt0 <= cnt0;
            cnt0     <= win0 ? 16'd1 : 16'd0;
        end else if (win0 && cnt0 != 16'hFFFF) begin
            cnt0 <= cnt0 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - directed table-driven bench for layer_compositor (NUM_LAYERS=2)
module tb_layer_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        blank, vblank, hs_in, vs_in;
    logic [8:0]  off_row;
    logic [9:0]  off_col;
    logic [23:0] layer_rgb;
    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hs_out, vs_out, win_hit;
    logic [1:0]  win_layer;
`ifdef LAYER_COMPOSITOR_STATS_EN
    logic [15:0] win_cnt0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layer_compositor dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .blank(blank), .vblank(vblank),
        .hs_in(hs_in), .vs_in(vs_in), .off_row(off_row), .off_col(off_col),
        .layer_rgb(layer_rgb), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hs_out(hs_out), .vs_out(vs_out),
        .win_hit(win_hit), .win_layer(win_layer)
`ifdef LAYER_COMPOSITOR_STATS_EN
        , .win_cnt0(win_cnt0)
`endif
    );

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_px(input string name, input int rgb, input int hit, input int lay);
        chk({name, "_rgb"}, int'({vga_r, vga_g, vga_b}), rgb);
        chk({name, "_hit"}, int'(win_hit), hit);
        chk({name, "_layer"}, int'(win_layer), lay);
    endtask

    task automatic pix(input int r, input int c, input logic b, input int l0, input int l1);
        row       = 9'(r);
        col       = 10'(c);
        blank     = b;
        layer_rgb = {12'(l1), 12'(l0)};
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_wr   = 1'b1;
        cfg_addr = 3'(a);
        cfg_data = 12'(d);
        step(1);
        cfg_wr   = 1'b0;
    endtask

    task automatic vblank_pulse();
        vblank = 1'b1;
        step(1);
        vblank = 1'b0;
        step(1);
    endtask

    typedef struct {
        int   r;
        int   c;
        logic b;
        int   l0;
        int   l1;
        int   rgb;
        int   hit;
        int   lay;
    } vec_t;

    vec_t vecs[14];
    logic [15:0] hpat, vpat;

    initial begin
        vecs[0]  = '{100, 210, 1'b0, 'h000, 'h0F0, 'h0F0, 1, 1};
        vecs[1]  = '{100, 210, 1'b0, 'hA50, 'h0F0, 'hA50, 1, 0};
        vecs[2]  = '{ 50, 210, 1'b0, 'hA50, 'h0F0, 'hFFF, 0, 2};
        vecs[3]  = '{100, 210, 1'b1, 'hA50, 'h0F0, 'h000, 0, 2};
        vecs[4]  = '{100, 207, 1'b0, 'hA50, 'h0F0, 'hFFF, 0, 2};
        vecs[5]  = '{100, 208, 1'b0, 'hA50, 'h0F0, 'hA50, 1, 0};
        vecs[6]  = '{100, 431, 1'b0, 'hA50, 'h0F0, 'hA50, 1, 0};
        vecs[7]  = '{100, 432, 1'b0, 'hA50, 'h0F0, 'hFFF, 0, 2};
        vecs[8]  = '{ 95, 300, 1'b0, 'h123, 'h0F0, 'hFFF, 0, 2};
        vecs[9]  = '{ 96, 300, 1'b0, 'h123, 'h0F0, 'h123, 1, 0};
        vecs[10] = '{383, 300, 1'b0, 'h000, 'h456, 'h456, 1, 1};
        vecs[11] = '{384, 300, 1'b0, 'h000, 'h456, 'hFFF, 0, 2};
        vecs[12] = '{200, 300, 1'b0, 'h000, 'h000, 'h000, 1, 2};
        vecs[13] = '{200, 300, 1'b1, 'h000, 'h000, 'h000, 0, 2};

        rst = 1'b1; vblank = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
        pix(100, 210, 1'b0, 'hA50, 'h0F0);
        step(3);
        chk_px("reset", 0, 0, 2);
        chk("reset_hs", int'(hs_out), 0);
        chk("reset_vs", int'(vs_out), 0);
        rst = 1'b0; hs_in = 1'b0; vs_in = 1'b0;

        chk("off_row", int'(off_row), 4);
        chk("off_col", int'(off_col), 2);
        pix(50, 200, 1'b0, 0, 0);
        #1;
        chk("off_row_wrap", int'(off_row), 466);
        chk("off_col_wrap", int'(off_col), 1016);

        for (int i = 0; i < 14; i++) begin
            pix(vecs[i].r, vecs[i].c, vecs[i].b, vecs[i].l0, vecs[i].l1);
            step(2);
            chk_px($sformatf("vec%0d", i), vecs[i].rgb, vecs[i].hit, vecs[i].lay);
        end

        // Key write during active video is held in the shadow until the vblank rise.
        pix(100, 210, 1'b0, 'hA50, 'h0F0);
        cfg_write(0, 'hA50);
        step(3);
        chk_px("key_pending", 'hA50, 1, 0);
        vblank_pulse();
        step(2);
        chk_px("key_committed", 'h0F0, 1, 1);

        // Mask write on the exact rise cycle waits for the following rise.
        step(2);
        vblank   = 1'b1;
        cfg_wr   = 1'b1;
        cfg_addr = 3'd2;
        cfg_data = 12'h000;
        step(1);
        cfg_wr = 1'b0;
        step(2);
        chk_px("mask_same_edge", 'h0F0, 1, 1);
        vblank = 1'b0;
        step(1);
        chk_px("mask_still_old", 'h0F0, 1, 1);
        vblank_pulse();
        step(2);
        chk_px("mask_committed", 'h000, 1, 2);

        cfg_write(4, 'h123);
        cfg_write(3, 'hF00);
        cfg_write(7, 'h777);
        vblank_pulse();
        step(2);
        chk_px("bg_color", 'h123, 1, 2);
        pix(50, 210, 1'b0, 'hA50, 'h0F0);
        step(2);
        chk_px("border_color", 'hF00, 0, 2);

        hpat = 16'b1011_0010_1110_0101;
        vpat = 16'b0110_1001_0011_1100;
        for (int k = 0; k < 18; k++) begin
            hs_in = (k < 16) ? hpat[k] : 1'b0;
            vs_in = (k < 16) ? vpat[k] : 1'b0;
            step(1);
            if (k >= 1 && k <= 16) begin
                chk($sformatf("hs_dly%0d", k), int'(hs_out), int'(hpat[k-1]));
                chk($sformatf("vs_dly%0d", k), int'(vs_out), int'(vpat[k-1]));
            end
        end

        // Reset in mid-line with non-default config active.
        pix(100, 210, 1'b0, 'hA50, 'h0F0);
        hs_in = 1'b1; vs_in = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        chk_px("midrst", 0, 0, 2);
        chk("midrst_hs", int'(hs_out), 0);
        chk("midrst_vs", int'(vs_out), 0);
        rst = 1'b0;
        step(2);
        chk_px("post_rst", 'hA50, 1, 0);
        chk("post_rst_hs", int'(hs_out), 1);
        pix(50, 210, 1'b0, 'hA50, 'h0F0);
        step(2);
        chk_px("post_rst_border", 'hFFF, 0, 2);
        hs_in = 1'b0; vs_in = 1'b0;

`ifdef LAYER_COMPOSITOR_STATS_EN
        pix(100, 210, 1'b1, 'hA50, 'h0F0);
        step(3);
        vblank_pulse();
        pix(100, 210, 1'b0, 'hA50, 'h0F0);
        step(10);
        pix(100, 210, 1'b1, 'hA50, 'h0F0);
        step(3);
        vblank_pulse();
        chk("win_cnt0_10", int'(win_cnt0), 10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
